// File: rtl/merge_arb_pkg.sv
// Shared constants and helpers for the round-robin merge arbiter.
// Index arithmetic runs at a fixed 3-bit width, which is enough for up to 8 requesters.
package merge_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int BURST_W = 4;

    // Width of the select index, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
        return ((int'(idx) + 1) >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/merge_arbiter_rr_pick.sv
// Combinational round-robin pick: the owner keeps the grant while its burst budget lasts,
// otherwise the search starts at owner+1 and wraps so that the owner is tried last.
module rr_pick
    import merge_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]              valid,
    input  logic [sel_width(NUM_REQ)-1:0]   owner,
    input  logic                            burst_ok,
    output logic [sel_width(NUM_REQ)-1:0]   pick,
    output logic                            any_valid
);

    localparam int SEL_W = sel_width(NUM_REQ);

    logic [MAX_REQ-1:0] valid_ext;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   found_idx;
    logic               found;

    assign valid_ext = MAX_REQ'(valid);

    always_comb begin
        idx       = IDX_W'(owner);
        found     = 1'b0;
        found_idx = IDX_W'(owner);
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = next_idx(idx, NUM_REQ);
            if (!found && valid_ext[idx]) begin
                found     = 1'b1;
                found_idx = idx;
            end
        end
        if (valid_ext[IDX_W'(owner)] && burst_ok) begin
            found_idx = IDX_W'(owner);
        end
        pick      = SEL_W'(found_idx);
        any_valid = |valid;
    end

endmodule

// File: rtl/merge_arbiter.sv
// Round-robin, burst-limited arbiter feeding a single registered output slot.
// out_sel is the merge select for the token currently held in out_data.
module merge_arbiter
    import merge_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH     = 33,
    parameter int MAX_BURST = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              in_valid,
    output logic [NUM_REQ-1:0]              in_ready,
    input  logic [NUM_REQ*WIDTH-1:0]        in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [sel_width(NUM_REQ)-1:0]   out_sel
);

    localparam int SEL_W = sel_width(NUM_REQ);

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [SEL_W-1:0]   pick;
    logic               any_valid;
    logic               burst_ok;
    logic               slot_free;
    logic               accept;

    // A zero count means nobody holds the grant yet, so after reset requester 0 wins a tie.
    assign burst_ok = (burst_cnt_q != '0) && (burst_cnt_q < BURST_W'(MAX_BURST));

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .valid    (in_valid),
        .owner    (owner_q),
        .burst_ok (burst_ok),
        .pick     (pick),
        .any_valid(any_valid)
    );

    always_comb begin
        slot_free   = !out_valid_q || out_ready;
        accept      = slot_free && any_valid && !reset;
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (pick == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(pick)*WIDTH +: WIDTH];
            out_sel_d   = pick;
            owner_d     = pick;
            // Owner regranted after exhausting its budget (wrap case) restarts at one.
            burst_cnt_d = ((pick == owner_q) && burst_ok) ? burst_cnt_q + 1'b1 : BURST_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            owner_q     <= SEL_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_merge_arbiter.sv
// Scoreboard bench for merge_arbiter: dut_a runs with MAX_BURST=4, dut_b with MAX_BURST=1.
// Requesters are token queues; expected output order is queued up front and popped on each handshake.
module tb_merge_arbiter;

    typedef struct packed {
        logic        sel;
        logic [32:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]  in_valid_a, in_ready_a, in_valid_b, in_ready_b;
    logic [65:0] in_data_a, in_data_b;
    logic        out_valid_a, out_ready_a, out_valid_b, out_ready_b;
    logic [32:0] out_data_a, out_data_b;
    logic        out_sel_a, out_sel_b;

    // Queues 0/1 feed dut_a requesters 0/1, queues 2/3 feed dut_b.
    logic [32:0] src_q [4][$];
    exp_t        exp_a[$];
    exp_t        exp_b[$];

    logic [1:0]  snap_in_ready_a;
    logic        snap_out_valid_a;
    logic [32:0] snap_out_data_a;
    logic        snap_out_sel_a;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycles;

    always #5 clk = ~clk;

    merge_arbiter #(.NUM_REQ(2), .WIDTH(33), .MAX_BURST(4)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .in_data  (in_data_a),
        .out_valid(out_valid_a),
        .out_ready(out_ready_a),
        .out_data (out_data_a),
        .out_sel  (out_sel_a)
    );

    merge_arbiter #(.NUM_REQ(2), .WIDTH(33), .MAX_BURST(1)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .in_data  (in_data_b),
        .out_valid(out_valid_b),
        .out_ready(out_ready_b),
        .out_data (out_data_b),
        .out_sel  (out_sel_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [32:0] front(input int q);
        return (src_q[q].size() != 0) ? src_q[q][0] : 33'h0;
    endfunction

    task automatic applyStimulus();
        in_valid_a = {src_q[1].size() != 0, src_q[0].size() != 0};
        in_valid_b = {src_q[3].size() != 0, src_q[2].size() != 0};
        in_data_a  = {front(1), front(0)};
        in_data_b  = {front(3), front(2)};
    endtask

    task automatic stepCycle();
        logic [1:0] acc_a;
        logic [1:0] acc_b;
        exp_t       e;
        @(negedge clk);
        snap_in_ready_a  = in_ready_a;
        snap_out_valid_a = out_valid_a;
        snap_out_data_a  = out_data_a;
        snap_out_sel_a   = out_sel_a;
        checkOutput("a_ready_onehot", 64'($countones(in_ready_a) <= 1), 64'd1);
        if (out_valid_a && out_ready_a) begin
            if (exp_a.size() == 0) begin
                checkOutput("a_unexpected_token", 64'(out_data_a), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_a.pop_front();
                checkOutput("a_data", 64'(out_data_a), 64'(e.data));
                checkOutput("a_sel", 64'(out_sel_a), 64'(e.sel));
            end
        end
        if (out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) begin
                checkOutput("b_unexpected_token", 64'(out_data_b), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_b.pop_front();
                checkOutput("b_data", 64'(out_data_b), 64'(e.data));
                checkOutput("b_sel", 64'(out_sel_b), 64'(e.sel));
            end
        end
        acc_a = in_valid_a & in_ready_a;
        acc_b = in_valid_b & in_ready_b;
        @(posedge clk);
        #1;
        if (acc_a[0]) void'(src_q[0].pop_front());
        if (acc_a[1]) void'(src_q[1].pop_front());
        if (acc_b[0]) void'(src_q[2].pop_front());
        if (acc_b[1]) void'(src_q[3].pop_front());
        applyStimulus();
    endtask

    task automatic runUntilDrained(input int budget, output int n);
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
            stepCycle();
            n++;
        end
        if (exp_a.size() + exp_b.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_a.size() + exp_b.size()), 64'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;

        // Both requesters of both DUTs valid while reset is held.
        for (int k = 0; k < 8; k++) begin
            src_q[0].push_back(33'(k));
            src_q[1].push_back(33'(256 + k));
        end
        for (int k = 0; k < 4; k++) begin
            src_q[2].push_back(33'(8'hA0 + k));
            src_q[3].push_back(33'(8'hB0 + k));
        end
        applyStimulus();
        stepCycle();
        checkOutput("rst_in_ready_1", 64'(snap_in_ready_a), 64'd0);
        stepCycle();
        checkOutput("rst_in_ready_2", 64'(snap_in_ready_a), 64'd0);
        checkOutput("rst_out_valid", 64'(snap_out_valid_a), 64'd0);
        checkOutput("rst_out_data", 64'(snap_out_data_a), 64'd0);
        checkOutput("rst_out_sel", 64'(snap_out_sel_a), 64'd0);

        // Bursts of four on dut_a, strict alternation on dut_b.
        for (int blk = 0; blk < 2; blk++)
            for (int r = 0; r < 2; r++)
                for (int k = 0; k < 4; k++)
                    exp_a.push_back('{1'(r), 33'(r*256 + blk*4 + k)});
        for (int k = 0; k < 4; k++) begin
            exp_b.push_back('{1'b0, 33'(8'hA0 + k)});
            exp_b.push_back('{1'b1, 33'(8'hB0 + k)});
        end
        reset = 1'b0;
        stepCycle();
        checkOutput("s1_first_ready", 64'(snap_in_ready_a), 64'd1);
        checkOutput("s1_first_out_valid", 64'(snap_out_valid_a), 64'd0);
        runUntilDrained(60, cycles);
        checkOutput("s1_cycles", 64'(cycles + 1), 64'd17);

        // Lone requester 1 streams back-to-back across burst boundaries.
        for (int k = 0; k < 10; k++) begin
            src_q[1].push_back(33'(512 + k));
            exp_a.push_back('{1'b1, 33'(512 + k)});
        end
        applyStimulus();
        runUntilDrained(60, cycles);
        checkOutput("s3_cycles", 64'(cycles), 64'd11);

        // Downstream stall with a wide token held in the slot.
        out_ready_a = 1'b0;
        src_q[0].push_back(33'h1_2345_6789);
        src_q[0].push_back(33'h0_ABCD_0001);
        exp_a.push_back('{1'b0, 33'h1_2345_6789});
        exp_a.push_back('{1'b0, 33'h0_ABCD_0001});
        applyStimulus();
        stepCycle();
        checkOutput("s4_first_ready", 64'(snap_in_ready_a), 64'd1);
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            checkOutput("s4_stall_valid", 64'(snap_out_valid_a), 64'd1);
            checkOutput("s4_stall_data", 64'(snap_out_data_a), 64'h1_2345_6789);
            checkOutput("s4_stall_sel", 64'(snap_out_sel_a), 64'd0);
            checkOutput("s4_stall_ready", 64'(snap_in_ready_a), 64'd0);
        end
        out_ready_a = 1'b1;
        stepCycle();
        checkOutput("s4_release_ready", 64'(snap_in_ready_a), 64'd1);
        runUntilDrained(20, cycles);

        // Owner 0 is idle after a two-token burst; requester 1 then gets a fresh budget of four.
        for (int k = 0; k < 5; k++) src_q[1].push_back(33'(768 + k));
        for (int k = 0; k < 4; k++) exp_a.push_back('{1'b1, 33'(768 + k)});
        exp_a.push_back('{1'b0, 33'(1024)});
        exp_a.push_back('{1'b0, 33'(1025)});
        exp_a.push_back('{1'b1, 33'(772)});
        applyStimulus();
        stepCycle();
        checkOutput("s5_first_ready", 64'(snap_in_ready_a), 64'd2);
        src_q[0].push_back(33'(1024));
        src_q[0].push_back(33'(1025));
        applyStimulus();
        runUntilDrained(30, cycles);

        // Reset lands while a token sits in the slot; that token is dropped.
        out_ready_a = 1'b0;
        src_q[1].push_back(33'h0_DEAD_BEEF);
        applyStimulus();
        stepCycle();
        reset = 1'b1;
        src_q[0].push_back(33'h500);
        src_q[1].push_back(33'h501);
        applyStimulus();
        stepCycle();
        checkOutput("s6_reset_ready", 64'(snap_in_ready_a), 64'd0);
        checkOutput("s6_held_valid", 64'(snap_out_valid_a), 64'd1);
        checkOutput("s6_post_rst_valid", 64'(out_valid_a), 64'd0);
        checkOutput("s6_post_rst_sel", 64'(out_sel_a), 64'd0);
        checkOutput("s6_post_rst_data", 64'(out_data_a), 64'd0);
        reset       = 1'b0;
        out_ready_a = 1'b1;
        exp_a.push_back('{1'b0, 33'h500});
        exp_a.push_back('{1'b1, 33'h501});
        stepCycle();
        checkOutput("s6_tie_ready", 64'(snap_in_ready_a), 64'd1);
        runUntilDrained(20, cycles);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
